// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment table, blank code, widths.
// SEVENSEG_LZB_EN (optional) selects leading-zero blanking in sevenseg_scan_driver.
package sevenseg_pkg;

  localparam int DEF_N_DIGITS     = 8;
  localparam int DEF_DIGIT_PERIOD = 100000;
  localparam int DEF_BLANK_CYCLES = 16;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first so SEG_LUT[n] is the code for hex n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Counter width for n states; a single-state counter still needs one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W_DEF = width_of(DEF_DIGIT_PERIOD);
  localparam int DIG_W_DEF = width_of(DEF_N_DIGITS);

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_LUT[nibble];
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit common-anode hex display driver with per-frame input latch.
// Define SEVENSEG_LZB_EN to blank digits above the most significant nonzero nibble.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS     = DEF_N_DIGITS,
  parameter int DIGIT_PERIOD = DEF_DIGIT_PERIOD,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*N_DIGITS-1:0]   HEX_IN,
  input  logic [N_DIGITS-1:0]     DP_IN,
  input  logic                    DISP_EN,
  output logic [N_DIGITS-1:0]     ANODE,
  output logic [6:0]              CATHODE,
  output logic                    DP,
  output logic                    FRAME_DONE
);

  localparam int CNT_W = width_of(DIGIT_PERIOD);
  localparam int DIG_W = width_of(N_DIGITS);

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DIGIT_PERIOD - 1);
  localparam logic [CNT_W-1:0]    BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0]    DIG_LAST  = DIG_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE_HOT0  = N_DIGITS'(1);

  logic [CNT_W-1:0]      cnt;
  logic [DIG_W-1:0]      dig;
  logic [4*N_DIGITS-1:0] shadow_hex;
  logic [N_DIGITS-1:0]   shadow_dp;

  logic       slot_end;
  logic       frame_end;
  logic       drive;
  logic [3:0] nibble;
  logic       dp_bit;
  logic [6:0] seg;
  logic       lz_blank;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (dig == DIG_LAST);
  assign drive     = (cnt >= BLANK_END) && DISP_EN;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
      dig <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      dig <= (dig == DIG_LAST) ? '0 : dig + DIG_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Shadow copy is taken only on the last cycle of the last slot so a frame never tears.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow_hex <= '0;
      shadow_dp  <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= frame_end;
      if (frame_end) begin
        shadow_hex <= HEX_IN;
        shadow_dp  <= DP_IN;
      end
    end
  end

  always_comb begin
    nibble = 4'h0;
    dp_bit = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (dig == DIG_W'(i)) begin
        nibble = shadow_hex[4*i +: 4];
        dp_bit = shadow_dp[i];
      end
    end
  end

`ifdef SEVENSEG_LZB_EN
  logic [DIG_W-1:0] msd;

  // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 is always shown.
  always_comb begin
    msd = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (shadow_hex[4*i +: 4] != 4'h0) begin
        msd = DIG_W'(i);
      end
    end
    lz_blank = (dig > msd);
  end
`else
  assign lz_blank = 1'b0;
`endif

  sevenseg_hex_decode u_decode (
    .nibble (nibble),
    .seg    (seg)
  );

  // Outputs lag the counter by one cycle; the blank phase guards every digit change.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ANODE   <= '1;
      CATHODE <= SEG_BLANK;
      DP      <= 1'b1;
    end else if (drive) begin
      ANODE   <= ~(ONE_HOT0 << dig);
      CATHODE <= lz_blank ? SEG_BLANK : seg;
      DP      <= ~dp_bit;
    end else begin
      ANODE   <= '1;
      CATHODE <= SEG_BLANK;
      DP      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with DIGIT_PERIOD=8, BLANK_CYCLES=2 (64-cycle frame).
module tb_sevenseg_scan_driver;

  logic        CLK;
  logic        RESET;
  logic [31:0] HEX_IN;
  logic [7:0]  DP_IN;
  logic        DISP_EN;
  logic [7:0]  ANODE;
  logic [6:0]  CATHODE;
  logic        DP;
  logic        FRAME_DONE;

  int checks = 0;
  int fails  = 0;

  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevenseg_scan_driver #(
    .N_DIGITS     (8),
    .DIGIT_PERIOD (8),
    .BLANK_CYCLES (2)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .HEX_IN     (HEX_IN),
    .DP_IN      (DP_IN),
    .DISP_EN    (DISP_EN),
    .ANODE      (ANODE),
    .CATHODE    (CATHODE),
    .DP         (DP),
    .FRAME_DONE (FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_code(input logic [31:0] v, input int d);
    logic [3:0] nib;
    int msd;
    msd = 0;
    for (int i = 0; i < 8; i++) begin
      if (((v >> (4*i)) & 32'hF) != 32'h0) msd = i;
    end
    nib = 4'((v >> (4*d)) & 32'hF);
`ifdef SEVENSEG_LZB_EN
    if (d > msd) return 7'h7F;
`endif
    return lut[nib];
  endfunction

  // One full 64-edge frame; edges dis_lo..dis_hi are driven with DISP_EN=0.
  task automatic run_frame(input string name, input logic [31:0] shown, input logic [7:0] dps,
                           input int dis_lo, input int dis_hi);
    int c, d;
    logic blank;
    for (int j = 1; j <= 64; j++) begin
      DISP_EN = !(j >= dis_lo && j <= dis_hi);
      @(posedge CLK);
      #1;
      c = (j - 1) % 8;
      d = (j - 1) / 8;
      blank = (c < 2) || !DISP_EN;
      chk({name, ".anode"}, ANODE, blank ? 8'hFF : ~(8'h01 << d));
      chk({name, ".cathode"}, {1'b0, CATHODE}, blank ? 8'h7F : {1'b0, exp_code(shown, d)});
      chk({name, ".dp"}, {7'h0, DP}, blank ? 8'h01 : {7'h0, ~dps[d]});
      chk({name, ".frame_done"}, {7'h0, FRAME_DONE}, (j == 64) ? 8'h01 : 8'h00);
    end
    DISP_EN = 1'b1;
  endtask

  initial begin
    RESET   = 1'b1;
    HEX_IN  = 32'h12345678;
    DP_IN   = 8'h00;
    DISP_EN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.anode", ANODE, 8'hFF);
    chk("rst.cathode", {1'b0, CATHODE}, 8'h7F);
    chk("rst.dp", {7'h0, DP}, 8'h01);
    chk("rst.frame_done", {7'h0, FRAME_DONE}, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;

    run_frame("f1_zero", 32'h0, 8'h00, 0, -1);
    // Frame 2 latched 12345678 at edge 64; this change must wait a full frame.
    HEX_IN = 32'hDEADBEEF;
    DP_IN  = 8'h04;
    run_frame("f2_hex", 32'h12345678, 8'h00, 0, -1);
    run_frame("f3_dead", 32'hDEADBEEF, 8'h04, 0, -1);
    run_frame("f4_dis", 32'hDEADBEEF, 8'h04, 9, 28);

    repeat (44) @(posedge CLK);
    #1;
    chk("pre_rst.anode", ANODE, 8'hDF);
    chk("pre_rst.cathode", {1'b0, CATHODE}, 8'h08);
    RESET = 1'b1;
    #1;
    chk("async_rst.anode", ANODE, 8'hFF);
    chk("async_rst.cathode", {1'b0, CATHODE}, 8'h7F);
    chk("async_rst.dp", {7'h0, DP}, 8'h01);
    HEX_IN = 32'h000000A0;
    @(negedge CLK);
    RESET = 1'b0;

    run_frame("f6_zero", 32'h0, 8'h00, 0, -1);
    run_frame("f7_a0", 32'h000000A0, 8'h04, 0, -1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
